// File: rtl/clock_time_counter.sv
// -----------------------------------------------------------------------------
// clock_time_counter
//
// 24-hour wall clock with BCD digit outputs and a New Year indicator.
// A prescaler divides CLK down to a one-second tick. The tick advances a
// binary seconds counter, and that counter carries into BCD minutes and hours.
// Set mode freezes timekeeping and lets the user step minutes and hours.
//
// Parameters
//   TICK_DIV      CLK cycles per one-second tick (>= 2)
//
// Ports
//   CLK           system clock, rising edge
//   RST_N         asynchronous active-low reset
//   set_mode      1 = time-set mode (prescaler and seconds held at 0)
//   inc_min       minute step request (set mode only)
//   inc_hour      hour step request (set mode only)
//   ny_eve        1 = today is 31 December
//   h_tens .. m_units  BCD digits HH:MM
//   ny_countdown  high during 23:50..23:59 on New Year's Eve (run mode)
//   ny_pulse      one-cycle strobe on the 23:59:59 -> 00:00:00 rollover
//
// Build option
//   BUTTON_SYNC_EN  when defined, inc_min/inc_hour pass through a two-flop
//                   synchroniser and rising-edge detector (one step per
//                   press, applied 3 cycles after the input rises). When
//                   undefined, they are synchronous level requests
//                   (one step per cycle high).
// -----------------------------------------------------------------------------
module clock_time_counter #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  input  logic       ny_eve,
  output logic [3:0] h_tens,
  output logic [3:0] h_units,
  output logic [3:0] m_tens,
  output logic [3:0] m_units,
  output logic       ny_countdown,
  output logic       ny_pulse
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  // Next minute value, modulo 60, in BCD {tens, units}.
  function automatic logic [7:0] bcd_min_next(input logic [3:0] tens,
                                              input logic [3:0] units);
    logic [7:0] nxt;
    if (units == 4'd9) begin
      nxt = (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
    end else begin
      nxt = {tens, units + 4'd1};
    end
    return nxt;
  endfunction

  // Next hour value, modulo 24, in BCD {tens, units}.
  function automatic logic [7:0] bcd_hour_next(input logic [3:0] tens,
                                               input logic [3:0] units);
    logic [7:0] nxt;
    if (tens == 4'd2 && units == 4'd3) begin
      nxt = 8'h00;
    end else if (units == 4'd9) begin
      nxt = {tens + 4'd1, 4'd0};
    end else begin
      nxt = {tens, units + 4'd1};
    end
    return nxt;
  endfunction

  logic [PS_W-1:0] ps_cnt;
  logic [5:0]      sec_cnt;
  logic            tick;
  logic            min_ev;
  logic            hour_ev;
  logic            min_at_59;
  logic            hour_at_23;
  logic [7:0]      min_nxt;
  logic [7:0]      hour_nxt;

  assign tick       = (ps_cnt == PS_MAX);
  assign min_at_59  = (m_tens == 4'd5) && (m_units == 4'd9);
  assign hour_at_23 = (h_tens == 4'd2) && (h_units == 4'd3);
  assign min_nxt    = bcd_min_next(m_tens, m_units);
  assign hour_nxt   = bcd_hour_next(h_tens, h_units);

`ifdef BUTTON_SYNC_EN
  // [0],[1] form the synchroniser; [2] holds the previous synchronised
  // level so a press of any length yields a single step.
  logic [2:0] min_sync;
  logic [2:0] hour_sync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      min_sync  <= 3'b000;
      hour_sync <= 3'b000;
    end else begin
      min_sync  <= {min_sync[1:0], inc_min};
      hour_sync <= {hour_sync[1:0], inc_hour};
    end
  end

  assign min_ev  = min_sync[1] & ~min_sync[2];
  assign hour_ev = hour_sync[1] & ~hour_sync[2];
`else
  assign min_ev  = inc_min;
  assign hour_ev = inc_hour;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ps_cnt   <= '0;
      sec_cnt  <= 6'd0;
      m_tens   <= 4'd0;
      m_units  <= 4'd0;
      h_tens   <= 4'd0;
      h_units  <= 4'd0;
      ny_pulse <= 1'b0;
    end else begin
      ny_pulse <= 1'b0;
      if (set_mode) begin
        // Set mode wins over a coincident tick; minute steps never carry.
        ps_cnt  <= '0;
        sec_cnt <= 6'd0;
        if (min_ev) begin
          {m_tens, m_units} <= min_nxt;
        end
        if (hour_ev) begin
          {h_tens, h_units} <= hour_nxt;
        end
      end else if (tick) begin
        ps_cnt <= '0;
        if (sec_cnt == 6'd59) begin
          sec_cnt           <= 6'd0;
          {m_tens, m_units} <= min_nxt;
          if (min_at_59) begin
            {h_tens, h_units} <= hour_nxt;
            // Strobe lands on the same edge the digits become 00:00.
            ny_pulse <= ny_eve & hour_at_23;
          end
        end else begin
          sec_cnt <= sec_cnt + 6'd1;
        end
      end else begin
        ps_cnt <= ps_cnt + 1'b1;
      end
    end
  end

  // Combinational decode so the flag changes with the digits; RST_N gating
  // keeps it low throughout reset.
  assign ny_countdown = RST_N & ny_eve & ~set_mode & hour_at_23 &
                        (m_tens == 4'd5);

endmodule

// File: tb/tb_clock_time_counter.sv
module tb_clock_time_counter;

  localparam int TD = 4;

  logic       CLK;
  logic       RST_N;
  logic       set_mode;
  logic       inc_min;
  logic       inc_hour;
  logic       ny_eve;
  logic [3:0] h_tens;
  logic [3:0] h_units;
  logic [3:0] m_tens;
  logic [3:0] m_units;
  logic       ny_countdown;
  logic       ny_pulse;

  clock_time_counter #(.TICK_DIV(TD)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .set_mode(set_mode),
    .inc_min(inc_min),
    .inc_hour(inc_hour),
    .ny_eve(ny_eve),
    .h_tens(h_tens),
    .h_units(h_units),
    .m_tens(m_tens),
    .m_units(m_units),
    .ny_countdown(ny_countdown),
    .ny_pulse(ny_pulse)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total;
  int bad;

  // Reference model: time of day as plain integers.
  int md_ps;
  int md_s;
  int md_m;
  int md_h;
  bit md_pulse;
`ifdef BUTTON_SYNC_EN
  // Input samples at previous edges: [0] = last edge, [1] = two ago, [2] = three ago.
  bit [2:0] hm;
  bit [2:0] hh;
`endif

  typedef struct {
    int pre_h;
    int pre_m;
    bit sm;
    bit im;
    bit ih;
    int exp_h;
    int exp_m;
  } vec_t;

  vec_t tbl[7];

  task automatic model_clear();
    md_ps = 0; md_s = 0; md_m = 0; md_h = 0; md_pulse = 0;
`ifdef BUTTON_SYNC_EN
    hm = 3'b000; hh = 3'b000;
`endif
  endtask

  task automatic model_next();
    bit em;
    bit eh;
    int t;
    if (!RST_N) begin
      model_clear();
      return;
    end
`ifdef BUTTON_SYNC_EN
    em = hm[1] & ~hm[2];
    eh = hh[1] & ~hh[2];
    hm = {hm[1:0], inc_min};
    hh = {hh[1:0], inc_hour};
`else
    em = inc_min;
    eh = inc_hour;
`endif
    md_pulse = 0;
    if (set_mode) begin
      md_ps = 0;
      md_s  = 0;
      if (em) md_m = (md_m + 1) % 60;
      if (eh) md_h = (md_h + 1) % 24;
    end else if (md_ps == TD - 1) begin
      md_ps = 0;
      t = md_h * 3600 + md_m * 60 + md_s + 1;
      if (t == 86400) begin
        t = 0;
        md_pulse = ny_eve;
      end
      md_h = t / 3600;
      md_m = (t / 60) % 60;
      md_s = t % 60;
    end else begin
      md_ps = md_ps + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_time(input string name, input int h, input int m);
    logic [15:0] e;
    e = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    check(name, {16'd0, h_tens, h_units, m_tens, m_units}, {16'd0, e});
  endtask

  task automatic check_all(input string name);
    logic [17:0] e;
    bit cd;
    cd = RST_N && ny_eve && !set_mode && md_h == 23 && md_m >= 50;
    e = {4'(md_h / 10), 4'(md_h % 10), 4'(md_m / 10), 4'(md_m % 10), cd, md_pulse};
    check(name, {14'd0, h_tens, h_units, m_tens, m_units, ny_countdown, ny_pulse},
          {14'd0, e});
  endtask

  // One clock: model steps on the inputs present before the edge, then
  // the bench resumes 1 time unit after the edge.
  task automatic clk1();
    model_next();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  task automatic press(input bit im, input bit ih);
    inc_min  = im;
    inc_hour = ih;
    clk1();
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    clk1();
`ifdef BUTTON_SYNC_EN
    clk1();
    clk1();
`endif
  endtask

  // Requires set_mode high.
  task automatic set_time(input int th, input int tm);
    int dh;
    int dm;
    dh = (th - md_h + 24) % 24;
    dm = (tm - md_m + 60) % 60;
    for (int i = 0; i < ((dh > dm) ? dh : dm); i++) press(i < dm, i < dh);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST_N    = 1'b0;
    set_mode = 1'b0;
    inc_min  = 1'b0;
    inc_hour = 1'b0;
    ny_eve   = 1'b1;
    model_clear();

    tbl[0] = '{9, 59, 1, 1, 0, 9, 0};
    tbl[1] = '{23, 15, 1, 0, 1, 0, 15};
    tbl[2] = '{12, 34, 1, 1, 1, 13, 35};
    tbl[3] = '{0, 0, 1, 0, 1, 1, 0};
    tbl[4] = '{19, 9, 1, 1, 0, 19, 10};
    tbl[5] = '{23, 59, 1, 1, 1, 0, 0};
    tbl[6] = '{8, 30, 0, 1, 1, 8, 30};

    // Reset state, ny_eve high
    #12;
    check_time("rst_digits", 0, 0);
    check("rst_countdown", {31'd0, ny_countdown}, 32'd0);
    check("rst_pulse", {31'd0, ny_pulse}, 32'd0);
    run(2);
    RST_N  = 1'b1;
    ny_eve = 1'b0;

    // Free run: 240 ticks of 4 cycles
    run(959);
    check_time("run_959", 0, 3);
    run(1);
    check_time("run_960", 0, 4);

    // Set-mode table
    ny_eve = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_mode = 1'b1;
      set_time(tbl[i].pre_h, tbl[i].pre_m);
      set_mode = tbl[i].sm;
      press(tbl[i].im, tbl[i].ih);
      check_time($sformatf("tbl%0d_time", i), tbl[i].exp_h, tbl[i].exp_m);
      check($sformatf("tbl%0d_pulse", i), {31'd0, ny_pulse}, 32'd0);
      check($sformatf("tbl%0d_cd", i), {31'd0, ny_countdown}, 32'd0);
      set_mode = 1'b1;
      clk1();
    end

    // Countdown window and New Year rollover
    set_time(23, 49);
    set_mode = 1'b0;
    run(239);
    check_time("ny_2349", 23, 49);
    check("ny_cd_2349", {31'd0, ny_countdown}, 32'd0);
    run(1);
    check_time("ny_2350", 23, 50);
    check("ny_cd_2350", {31'd0, ny_countdown}, 32'd1);
    run(2160);
    check_time("ny_2359", 23, 59);
    check("ny_cd_2359", {31'd0, ny_countdown}, 32'd1);
    run(239);
    check("ny_pulse_pre", {31'd0, ny_pulse}, 32'd0);
    check("ny_cd_last", {31'd0, ny_countdown}, 32'd1);
    run(1);
    check_time("ny_0000", 0, 0);
    check("ny_pulse_hit", {31'd0, ny_pulse}, 32'd1);
    check("ny_cd_0000", {31'd0, ny_countdown}, 32'd0);
    run(1);
    check("ny_pulse_post", {31'd0, ny_pulse}, 32'd0);

    // Same rollover without New Year's Eve
    ny_eve   = 1'b0;
    set_mode = 1'b1;
    set_time(23, 59);
    set_mode = 1'b0;
    run(240);
    check_time("noeve_0000", 0, 0);
    check("noeve_pulse", {31'd0, ny_pulse}, 32'd0);

    // Asynchronous reset mid-second at 17:42
    set_mode = 1'b1;
    set_time(17, 42);
    set_mode = 1'b0;
    run(2);
    check_time("pre_rst", 17, 42);
    #2;
    RST_N    = 1'b0;
    set_mode = 1'b1;
    ny_eve   = 1'b1;
    model_clear();
    #1;
    check_time("async_rst", 0, 0);
    check("async_rst_cd", {31'd0, ny_countdown}, 32'd0);
    check("async_rst_pulse", {31'd0, ny_pulse}, 32'd0);
    clk1();
    RST_N    = 1'b1;
    set_mode = 1'b0;
    ny_eve   = 1'b0;
    run(239);
    check_time("restart_239", 0, 0);
    run(1);
    check_time("restart_240", 0, 1);

    // Held button for 10 cycles
    set_mode = 1'b1;
    clk1();
    inc_min = 1'b1;
    run(10);
    inc_min = 1'b0;
    run(5);
`ifdef BUTTON_SYNC_EN
    check_time("hold10", 0, 2);
`else
    check_time("hold10", 0, 11);
`endif

    // Randomized run against the model, starting near midnight
    ny_eve = 1'b1;
    set_time(23, 45);
    set_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      RST_N    = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 149) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 399) == 0) ny_eve = ~ny_eve;
      inc_min  = ($urandom_range(0, 3) == 0);
      inc_hour = ($urandom_range(0, 5) == 0);
      clk1();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
